// File: rtl/shift_register_universal.sv
// Universal shift register: parallel load, then shift N positions (left/right;
// logical, rotate or arithmetic) one per clock under a small IDLE/SHIFT sequencer.
//
// state | meaning
// IDLE  | waiting; accepts load (priority) or start
// SHIFT | one shift per clock until remaining reaches zero
module shift_register_universal #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_d;
  logic             sout_d;
  logic             done_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] count_clamped;
  logic [WIDTH-1:0] shifted;
  logic             shift_out;
  logic             fill;

  assign count_clamped = (shift_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_count;

  // One-position shift of the current word using the latched direction/mode.
  always_comb begin
    fill      = serial_in;
    shifted   = data_out;
    shift_out = 1'b0;
    if (!dir_q) begin
      if (mode_q == MODE_ROT)        fill = data_out[WIDTH-1];
      else if (mode_q == MODE_ARITH) fill = 1'b0;
      shifted   = {data_out[WIDTH-2:0], fill};
      shift_out = data_out[WIDTH-1];
    end else begin
      if (mode_q == MODE_ROT)        fill = data_out[0];
      else if (mode_q == MODE_ARITH) fill = data_out[WIDTH-1];
      shifted   = {fill, data_out[WIDTH-1:1]};
      shift_out = data_out[0];
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_out;
    sout_d      = serial_out;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          data_d = data_in;
        end else if (start) begin
          if (count_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = count_clamped;
            dir_d       = dir;
            mode_d      = mode;
            state_d     = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d      = shifted;
        sout_d      = shift_out;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_out    <= '0;
      serial_out  <= 1'b0;
      done        <= 1'b0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      data_out    <= data_d;
      serial_out  <= sout_d;
      done        <= done_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
    end
  end

  assign busy = (state_q == SHIFT);

endmodule
